sgmii_mgmt_initiator: RTL
=========================

Name: sgmii_mgmt_initiator

Overview:
- Wishbone-style bus master that drives the SGMII core's management register slave.
- After reset or a start request it writes the configuration sequence (mode, link timer, reg4, reg0 with AN enable/restart).
- It then polls status until AN complete and sync are both set, captures the link-partner ability and keeps monitoring the link.
- Sits between top-level strap parameters and the SGMII register block, replacing a host CPU in standalone designs.

Parameters:
- pModeReg, 16'h0003, value written to mode register (bit0 SGMII, bit1 PHY side, bit2 use local config).
- pLinkTimer, 21'h0_0C35, value written to link timer (lo 16 bits, then hi 5 bits).
- pReg4, 16'h01A0, value written to control reg 4.
- pReg0, 16'h1200, value written to control reg 0 (bit12 AN enable, bit9 AN restart).
- pPollInterval, 16'd1000, clocks between status reads (>=1).
- pMaxPolls, 16'd100, status reads without link-up before AN is restarted.
- pAckTimeout, 8'd64, clocks to wait for i_Ack before bus error.

Ports:
- i_Clk  in  1  system clock
- i_ARstLogic_H  in  1  asynchronous reset, active high
- i_Start  in  1  rising edge (re)starts the full sequence from any non-bus state
- o_Cyc  out  1  bus cycle
- o_Stb  out  1  strobe
- o_WEn  out  1  1=write, 0=read
- o8_Addr  out  8  byte address (register index << 2)
- o32_WrData  out  32  write data, upper 16 bits zero
- i32_RdData  in  32  read data
- i_Ack  in  1  transfer acknowledge
- i_Stall  in  1  slave stall (informational; the master holds the request until ack regardless)
- o_Busy  out  1  sequence in progress
- o_LinkUp  out  1  status bit5 (AN complete) and bit2 (sync) both seen set
- o_ANTimeout  out  1  sticky; pMaxPolls exceeded at least once
- o_BusErr  out  1  sticky; ack timeout occurred
- o16_LpAdvAbility  out  16  last captured register 5 value

Behaviour:
- Reset values:
  - All outputs 0, except o_Busy=1.
  - FSM enters WR_MODE the first clock after reset deasserts (auto-start).
- Register map (byte addresses): reg0=0x00, reg1 status=0x04, reg4=0x10, reg5=0x14, linktimer lo=0x20, linktimer hi=0x24, mode=0x7C.
- Bus handshake (slave edge-detects Cyc&Stb):
  - Assert Cyc, Stb, WEn, Addr, WrData together.
  - Hold all of them stable until the first cycle with i_Ack=1.
  - Deassert Cyc and Stb on the next clock.
  - Keep them low for exactly 1 idle cycle (GAP) before the next access.
  - On a read, latch i32_RdData in the cycle i_Ack=1.
  - i_Ack while Cyc=0 is ignored.
- Ack timeout:
  - An internal counter counts clocks with Cyc=1 and no ack.
  - On reaching pAckTimeout: drop Cyc/Stb, set o_BusErr, go to ERROR.
  - ERROR holds, with o_Busy=0, until i_Start rises.
- States:
  - IDLE → WR_MODE → WR_LT_LO → WR_LT_HI → WR_REG4 → WR_REG0 → POLL_WAIT → RD_STAT → (RD_LPA) → MONITOR; plus ERROR.
  - Each WR_/RD_ state performs exactly one bus access, followed by GAP.
- POLL_WAIT: count pPollInterval clocks, then go to RD_STAT.
- RD_STAT:
  - If rd[5]&rd[2]: go to RD_LPA. It reads 0x14, stores rd[15:0] into o16_LpAdvAbility, sets o_LinkUp=1, clears o_Busy, enters MONITOR.
  - Otherwise increment the poll count. When the count reaches pMaxPolls: set o_ANTimeout, clear the count, return to WR_REG0 (rewrites pReg0, restarting AN). Otherwise return to POLL_WAIT.
- MONITOR:
  - Every pPollInterval clocks, read 0x04.
  - If rd[5]&rd[2] is no longer true: o_LinkUp=0, o_Busy=1, poll count cleared, go to POLL_WAIT.
  - o16_LpAdvAbility holds its last value.
- i_Start:
  - A rising edge is detected with a 1-flop delay.
  - Acted on only when no bus access is outstanding (Cyc=0).
  - If it arrives during an access, it is remembered and taken after that access's GAP.
  - Effect: o_LinkUp=0, o_Busy=1, poll count cleared, go to WR_MODE. Sticky flags are not cleared.
- Reset mid-access drops Cyc/Stb immediately (async).
- Counters saturate, never wrap. pPollInterval=1 means a read every GAP+1 clocks.

Test Plan:
- Reset release with an auto-ack slave (1-cycle ack) → writes appear in order, with 1 idle cycle between accesses:
  - 0x7C=0003, 0x20=0C35, 0x24=0000, 0x10=01A0, 0x00=1200.
  - Then periodic reads of 0x04.
- Status returns 0x0024 on the 3rd poll → one read of 0x14 returning 0x4801 → o16_LpAdvAbility=0x4801, o_LinkUp=1, o_Busy=0.
- Status never sets bit5, pMaxPolls=4 → after the 4th read o_ANTimeout=1 and 0x00 is rewritten with 1200; polling resumes.
- Slave withholds ack, pAckTimeout=8 → Cyc drops after 8 clocks, o_BusErr=1, FSM idle; an i_Start pulse restarts from the 0x7C write.
- In MONITOR, status changes to 0x0020 → o_LinkUp falls after that read and o_Busy=1; restoring 0x0024 re-raises o_LinkUp after the 0x14 read.
- i_Start pulsed while Stb is held with a 3-cycle-delayed ack → the current access completes unchanged, GAP follows, then the 0x7C write starts.

Source files
------------

// File: rtl/sgmii_mgmt_initiator.sv
// Wishbone master that programs the SGMII management registers,
// waits for autonegotiation to finish and then keeps watching the link.
module sgmii_mgmt_initiator #(
  parameter logic [15:0] pModeReg      = 16'h0003,
  parameter logic [20:0] pLinkTimer    = 21'h0_0C35,
  parameter logic [15:0] pReg4         = 16'h01A0,
  parameter logic [15:0] pReg0         = 16'h1200,
  parameter logic [15:0] pPollInterval = 16'd1000,
  parameter logic [15:0] pMaxPolls     = 16'd100,
  parameter logic [7:0]  pAckTimeout   = 8'd64
) (
  input  logic        i_Clk,
  input  logic        i_ARstLogic_H,
  input  logic        i_Start,
  output logic        o_Cyc,
  output logic        o_Stb,
  output logic        o_WEn,
  output logic [7:0]  o8_Addr,
  output logic [31:0] o32_WrData,
  input  logic [31:0] i32_RdData,
  input  logic        i_Ack,
  input  logic        i_Stall,
  output logic        o_Busy,
  output logic        o_LinkUp,
  output logic        o_ANTimeout,
  output logic        o_BusErr,
  output logic [15:0] o16_LpAdvAbility
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_LT_LO,
    S_WR_LT_HI,
    S_WR_REG4,
    S_WR_REG0,
    S_POLL_WAIT,
    S_RD_STAT,
    S_RD_LPA,
    S_MONITOR,
    S_GAP,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      nxt;
  state_t      go_st;
  logic [15:0] wait_cnt;
  logic [15:0] poll_cnt;
  logic [7:0]  to_cnt;
  logic        start_q;
  logic        start_d;
  logic        start_pend;
  logic        start_rise;
  logic        take;
  logic        go;
  logic        restart;
  logic        wait_done;
  logic        stat_ok;
  logic        unused_bits;

  assign start_rise  = start_q & ~start_d;
  assign take        = start_rise | start_pend;
  assign wait_done   = wait_cnt >= (pPollInterval - 16'd1);
  assign stat_ok     = i32_RdData[5] & i32_RdData[2];
  assign unused_bits = ^{i_Stall, i32_RdData[31:16]};

  function automatic logic [7:0] addr_of(state_t s);
    case (s)
      S_WR_MODE:  return 8'h7C;
      S_WR_LT_LO: return 8'h20;
      S_WR_LT_HI: return 8'h24;
      S_WR_REG4:  return 8'h10;
      S_RD_STAT:  return 8'h04;
      S_RD_LPA:   return 8'h14;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] data_of(state_t s);
    case (s)
      S_WR_MODE:  return pModeReg;
      S_WR_LT_LO: return pLinkTimer[15:0];
      S_WR_LT_HI: return {11'h000, pLinkTimer[20:16]};
      S_WR_REG4:  return pReg4;
      S_WR_REG0:  return pReg0;
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic is_acc(state_t s);
    return s inside {S_WR_MODE, S_WR_LT_LO, S_WR_LT_HI,
                     S_WR_REG4, S_WR_REG0, S_RD_STAT, S_RD_LPA};
  endfunction

  function automatic logic is_wr(state_t s);
    return s inside {S_WR_MODE, S_WR_LT_LO, S_WR_LT_HI,
                     S_WR_REG4, S_WR_REG0};
  endfunction

  // Decide whether a new bus access is launched on this edge.
  always_comb begin
    go      = 1'b0;
    go_st   = S_WR_MODE;
    restart = 1'b0;
    case (state)
      S_IDLE: begin
        go      = 1'b1;
        restart = 1'b1;
      end
      S_GAP: begin
        if (take) begin
          go      = 1'b1;
          restart = 1'b1;
        end else if (is_acc(nxt)) begin
          go    = 1'b1;
          go_st = nxt;
        end
      end
      S_POLL_WAIT, S_MONITOR: begin
        if (take) begin
          go      = 1'b1;
          restart = 1'b1;
        end else if (wait_done) begin
          go    = 1'b1;
          go_st = S_RD_STAT;
        end
      end
      S_ERROR: begin
        if (take) begin
          go      = 1'b1;
          restart = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_ARstLogic_H) begin
    if (i_ARstLogic_H) begin
      state            <= S_IDLE;
      nxt              <= S_IDLE;
      wait_cnt         <= '0;
      poll_cnt         <= '0;
      to_cnt           <= '0;
      start_q          <= 1'b0;
      start_d          <= 1'b0;
      start_pend       <= 1'b0;
      o_Cyc            <= 1'b0;
      o_Stb            <= 1'b0;
      o_WEn            <= 1'b0;
      o8_Addr          <= '0;
      o32_WrData       <= '0;
      o_Busy           <= 1'b1;
      o_LinkUp         <= 1'b0;
      o_ANTimeout      <= 1'b0;
      o_BusErr         <= 1'b0;
      o16_LpAdvAbility <= '0;
    end else begin
      start_q <= i_Start;
      start_d <= start_q;
      if (restart) begin
        start_pend <= 1'b0;
      end else if (start_rise) begin
        start_pend <= 1'b1;
      end

      if (go) begin
        o_Cyc      <= 1'b1;
        o_Stb      <= 1'b1;
        o_WEn      <= is_wr(go_st);
        o8_Addr    <= addr_of(go_st);
        o32_WrData <= {16'h0000, data_of(go_st)};
        to_cnt     <= '0;
        state      <= go_st;
        if (restart) begin
          o_LinkUp <= 1'b0;
          o_Busy   <= 1'b1;
          poll_cnt <= '0;
        end
      end else begin
        case (state)
          S_GAP: begin
            state    <= nxt;
            wait_cnt <= '0;
          end
          S_POLL_WAIT, S_MONITOR: begin
            if (wait_cnt != 16'hFFFF) begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
          S_IDLE, S_ERROR: ;
          default: begin
            if (o_Cyc && i_Ack) begin
              o_Cyc <= 1'b0;
              o_Stb <= 1'b0;
              state <= S_GAP;
              case (state)
                S_WR_MODE:  nxt <= S_WR_LT_LO;
                S_WR_LT_LO: nxt <= S_WR_LT_HI;
                S_WR_LT_HI: nxt <= S_WR_REG4;
                S_WR_REG4:  nxt <= S_WR_REG0;
                S_RD_LPA: begin
                  o16_LpAdvAbility <= i32_RdData[15:0];
                  o_LinkUp         <= 1'b1;
                  o_Busy           <= 1'b0;
                  nxt              <= S_MONITOR;
                end
                S_RD_STAT: begin
                  if (o_LinkUp) begin
                    if (stat_ok) begin
                      nxt <= S_MONITOR;
                    end else begin
                      o_LinkUp <= 1'b0;
                      o_Busy   <= 1'b1;
                      poll_cnt <= '0;
                      nxt      <= S_POLL_WAIT;
                    end
                  end else if (stat_ok) begin
                    nxt <= S_RD_LPA;
                  end else if (poll_cnt >= pMaxPolls - 16'd1) begin
                    // Give up on this negotiation and rewrite reg0 to restart it.
                    o_ANTimeout <= 1'b1;
                    poll_cnt    <= '0;
                    nxt         <= S_WR_REG0;
                  end else begin
                    poll_cnt <= poll_cnt + 16'd1;
                    nxt      <= S_POLL_WAIT;
                  end
                end
                default: nxt <= S_POLL_WAIT;
              endcase
            end else if (o_Cyc) begin
              if (to_cnt >= pAckTimeout - 8'd1) begin
                o_Cyc    <= 1'b0;
                o_Stb    <= 1'b0;
                o_BusErr <= 1'b1;
                o_Busy   <= 1'b0;
                state    <= S_ERROR;
              end else begin
                to_cnt <= to_cnt + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
